// File: rtl/ps2_scancode_rx_if.sv
// Pin and result bundle for the PS/2 scancode receiver.
// master = the receiver (reads raw pins, drives the scancode outputs); slave = pin driver / PIO side.
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       code_valid;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output scancode,
        output code_valid,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  scancode,
        input  code_valid,
        input  frame_err
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver presenting the last good scancode as a level for a PIO input port.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise only the stop bit gates acceptance.
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               reset_n,
    ps2_scancode_rx_if.master  bus
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_s;
    logic                   data_s;

    logic                   filt_level;
    logic                   filt_prev;
    logic [FCW-1:0]         filt_cnt;
    logic                   fe;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift_reg;
    logic [TCW-1:0]         to_cnt;
    logic [7:0]             scancode_r;
    logic                   code_valid_r;
    logic                   frame_err_r;
    logic                   accept;
`ifdef PS2_RX_PARITY_CHECK_EN
    logic                   parity_ok;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
        end
    end

    assign clk_s  = clk_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_prev <= filt_level;
            if (clk_s != filt_level) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_level <= clk_s;
                    filt_cnt   <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fe = filt_prev & ~filt_level;

`ifdef PS2_RX_PARITY_CHECK_EN
    assign accept = data_s & parity_ok;
`else
    assign accept = data_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            to_cnt       <= '0;
            scancode_r   <= '0;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            parity_ok    <= 1'b0;
`endif
        end else begin
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;

            if (state == IDLE || fe)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;

            // A stalled frame is dropped silently so the next start bit is seen cleanly.
            if (state != IDLE && !fe && to_cnt == TCW'(TIMEOUT_CYCLES)) begin
                state  <= IDLE;
                to_cnt <= '0;
            end else if (fe) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= {data_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        parity_ok <= ^{shift_reg, data_s};
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        if (accept) begin
                            scancode_r   <= shift_reg;
                            code_valid_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.scancode   = scancode_r;
    assign bus.code_valid = code_valid_r;
    assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed self-checking bench for ps2_scancode_rx; expectations follow PS2_RX_PARITY_CHECK_EN when defined.
module tb_ps2_scancode_rx;

    localparam int HALF = 40;

    logic clk;
    logic reset_n;
    int   assertions;
    int   failures;
    int   valid_cnt;
    int   err_cnt;
    int   overlap_cnt;

    ps2_scancode_rx_if bus();

    ps2_scancode_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Pulse accounting runs alongside every test; deltas are checked by the tests.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.code_valid) valid_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.code_valid && bus.frame_err) overlap_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            wait_cycles(HALF);
            bus.ps2_clk = 1'b0;
            wait_cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        wait_cycles(HALF);
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits(make_frame(d, p, s), 11);
        wait_cycles(20);
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        wait_cycles(5);
        assertions++;
        if (bus.scancode !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_scancode got %h expected %h", bus.scancode, 8'h00);
        end
        assertions++;
        if (bus.code_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_code_valid got %b expected 0", bus.code_valid);
        end
        assertions++;
        if (bus.frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_frame_err got %b expected 0", bus.frame_err);
        end
        reset_n = 1'b1;
        wait_cycles(10);
    endtask

    task automatic test_clean_frame();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        assertions++;
        if (bus.scancode !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL clean_scancode got %h expected %h", bus.scancode, 8'h1C);
        end
        assertions++;
        if (valid_cnt - v0 !== 1) begin
            failures++;
            $display("[TB] FAIL clean_valid_pulses got %0d expected 1", valid_cnt - v0);
        end
        assertions++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("[TB] FAIL clean_err_pulses got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = valid_cnt;
        send_bits(make_frame(8'hF0, 1'b1, 1'b1), 11);
        assertions++;
        if (bus.scancode !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL b2b_first_scancode got %h expected %h", bus.scancode, 8'hF0);
        end
        send_frame(8'h1C, 1'b0, 1'b1);
        assertions++;
        if (bus.scancode !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL b2b_final_scancode got %h expected %h", bus.scancode, 8'h1C);
        end
        assertions++;
        if (valid_cnt - v0 !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_valid_pulses got %0d expected 2", valid_cnt - v0);
        end
    endtask

    task automatic test_parity();
        int v0, e0;
        logic [7:0] exp_code;
        int exp_v, exp_e;
`ifdef PS2_RX_PARITY_CHECK_EN
        exp_code = 8'h1C; exp_v = 0; exp_e = 1;
`else
        exp_code = 8'h5A; exp_v = 1; exp_e = 0;
`endif
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b1);
        assertions++;
        if (bus.scancode !== exp_code) begin
            failures++;
            $display("[TB] FAIL parity_scancode got %h expected %h", bus.scancode, exp_code);
        end
        assertions++;
        if (valid_cnt - v0 !== exp_v) begin
            failures++;
            $display("[TB] FAIL parity_valid_pulses got %0d expected %0d", valid_cnt - v0, exp_v);
        end
        assertions++;
        if (err_cnt - e0 !== exp_e) begin
            failures++;
            $display("[TB] FAIL parity_err_pulses got %0d expected %0d", err_cnt - e0, exp_e);
        end
    endtask

    task automatic test_timeout();
        int v0, e0;
        send_frame(8'h1C, 1'b0, 1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bits(make_frame(8'h5A, 1'b1, 1'b1), 5);
        wait_cycles(6000);
        assertions++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            failures++;
            $display("[TB] FAIL timeout_partial_pulses got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0));
        end
        assertions++;
        if (bus.scancode !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL timeout_partial_scancode got %h expected %h", bus.scancode, 8'h1C);
        end
        send_frame(8'h5A, 1'b1, 1'b1);
        assertions++;
        if (bus.scancode !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL timeout_next_scancode got %h expected %h", bus.scancode, 8'h5A);
        end
        assertions++;
        if (valid_cnt - v0 !== 1) begin
            failures++;
            $display("[TB] FAIL timeout_valid_pulses got %0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_glitch_and_bad_stop();
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        wait_cycles(3);
        bus.ps2_clk  = 1'b1;
        wait_cycles(5);
        bus.ps2_data = 1'b1;
        wait_cycles(50);
        assertions++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            failures++;
            $display("[TB] FAIL glitch_pulses got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0));
        end
        send_frame(8'h1C, 1'b0, 1'b1);
        assertions++;
        if (bus.scancode !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL glitch_next_scancode got %h expected %h", bus.scancode, 8'h1C);
        end
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        assertions++;
        if (err_cnt - e0 !== 1) begin
            failures++;
            $display("[TB] FAIL badstop_err_pulses got %0d expected 1", err_cnt - e0);
        end
        assertions++;
        if (valid_cnt - v0 !== 0) begin
            failures++;
            $display("[TB] FAIL badstop_valid_pulses got %0d expected 0", valid_cnt - v0);
        end
        assertions++;
        if (bus.scancode !== 8'h1C) begin
            failures++;
            $display("[TB] FAIL badstop_scancode got %h expected %h", bus.scancode, 8'h1C);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        send_bits(make_frame(8'hF0, 1'b1, 1'b1), 6);
        reset_n = 1'b0;
        wait_cycles(5);
        assertions++;
        if (bus.scancode !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midreset_scancode got %h expected %h", bus.scancode, 8'h00);
        end
        assertions++;
        if (bus.code_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_code_valid got %b expected 0", bus.code_valid);
        end
        reset_n = 1'b1;
        wait_cycles(10);
        v0 = valid_cnt;
        send_frame(8'h29, 1'b0, 1'b1);
        assertions++;
        if (bus.scancode !== 8'h29) begin
            failures++;
            $display("[TB] FAIL midreset_next_scancode got %h expected %h", bus.scancode, 8'h29);
        end
        assertions++;
        if (valid_cnt - v0 !== 1) begin
            failures++;
            $display("[TB] FAIL midreset_valid_pulses got %0d expected 1", valid_cnt - v0);
        end
    endtask

    task automatic test_exclusive();
        assertions++;
        if (overlap_cnt !== 0) begin
            failures++;
            $display("[TB] FAIL valid_err_overlap got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        assertions   = 0;
        failures     = 0;
        valid_cnt    = 0;
        err_cnt      = 0;
        overlap_cnt  = 0;
        reset_n      = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_clean_frame();
        test_back_to_back();
        test_parity();
        test_timeout();
        test_glitch_and_bad_stop();
        test_reset_midframe();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
